// File: rtl/seq_match_ctrl.sv
// Serial pattern detector with run control, match counting and optional target stop.
// Define SEQ_OVERLAP_EN to make detection overlapping (a match keeps the fill counter).
module seq_match_ctrl #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             in,
    input  logic             in_valid,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             done
);

    localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e            state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [CNT_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              match_q, match_d;
    logic              done_q, done_d;
    logic              hit;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        tgt_d   = tgt_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        done_d  = 1'b0;
        hit     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // start beats a simultaneous stop here since stop is not looked at
                if (start) begin
                    state_d = StRun;
                    pat_d   = cfg_pattern;
                    tgt_d   = cfg_target;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (in_valid) begin
                    hist_d = {hist_q[PAT_W-2:0], in};
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + 1'b1;
                    end
                    hit = (fill_d == FILL_FULL) && (hist_d == pat_q);
                end
                if (hit) begin
                    match_d = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`ifndef SEQ_OVERLAP_EN
                    fill_d = '0;
`endif
                end
                if ((hit && (tgt_q != '0) && (cnt_d == tgt_q)) || stop) begin
                    state_d = StFin;
                    done_d  = 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            pat_q   <= '0;
            tgt_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            tgt_q   <= tgt_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign match       = match_q;
    assign done        = done_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Bench for seq_match_ctrl: directed scenarios plus random traffic against a bit-queue model.
module tb_seq_match_ctrl;

    localparam int unsigned PAT_W   = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_OVERLAP_EN
    localparam int unsigned EXP_OV  = 2;
`else
    localparam int unsigned EXP_OV  = 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [CNT_W-1:0] cfg_target = '0;
    logic             in = 1'b0;
    logic             in_valid = 1'b0;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             done;

    seq_match_ctrl #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .cfg_pattern(cfg_pattern),
        .cfg_target (cfg_target),
        .in         (in),
        .in_valid   (in_valid),
        .busy       (busy),
        .match      (match),
        .match_count(match_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned pulses = 0;
    int unsigned dones = 0;

    // Model: phase 0 idle, 1 running, 2 finishing; bits holds the current detection window.
    int          m_phase = 0;
    int          m_bits[$];
    int unsigned m_pat = 0;
    int unsigned m_tgt = 0;
    int unsigned m_count = 0;
    bit          exp_match = 1'b0;
    bit          exp_done = 1'b0;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit st, input bit sp, input bit b, input bit v);
        bit          hit;
        int unsigned val;
        exp_match = 1'b0;
        exp_done  = 1'b0;
        if (!rst) begin
            m_phase = 0;
            m_count = 0;
            m_pat   = 0;
            m_tgt   = 0;
            m_bits.delete();
        end else begin
            case (m_phase)
                0: if (st) begin
                    m_phase = 1;
                    m_pat   = cfg_pattern;
                    m_tgt   = cfg_target;
                    m_count = 0;
                    m_bits.delete();
                end
                1: begin
                    hit = 1'b0;
                    if (v) begin
                        m_bits.push_back(b);
                        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                        val = 0;
                        foreach (m_bits[i]) val = (val << 1) | m_bits[i];
                        hit = (m_bits.size() == PAT_W) && (val == m_pat);
                    end
                    if (hit) begin
                        exp_match = 1'b1;
                        if (m_count < CNT_MAX) m_count++;
`ifndef SEQ_OVERLAP_EN
                        m_bits.delete();
`endif
                    end
                    if ((hit && m_tgt != 0 && m_count == m_tgt) || sp) begin
                        exp_done = 1'b1;
                        m_phase  = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit sp, input bit b, input bit v);
        reset    = rst;
        start    = st;
        stop     = sp;
        in       = b;
        in_valid = v;
        model_step(rst, st, sp, b, v);
        @(posedge clk);
        #1;
        check_eq("busy", busy, (m_phase == 1) ? 1 : 0);
        check_eq("match", match, exp_match);
        check_eq("done", done, exp_done);
        check_eq("match_count", match_count, m_count);
        if (match) pulses++;
        if (done) dones++;
    endtask

    task automatic feed(input int unsigned val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, 1'b0, 1'b0, val[i], 1'b1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset for two cycles
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_count", match_count, 0);

        // Stream 101010, pattern 1010, unlimited target
        cfg_pattern = 4'b1010;
        cfg_target  = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        feed(6'b101010, 6);
        check_eq("ov_pulses", pulses, EXP_OV);
        check_eq("ov_count", match_count, EXP_OV);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Target 2: done with the 2nd match, later bits ignored
        cfg_target = 2;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        dones = 0;
        feed(8'b10101010, 8);
        check_eq("tgt_done", done, 1);
        check_eq("tgt_match", match, 1);
        check_eq("tgt_count", match_count, 2);
        feed(4'b1010, 4);
        check_eq("tgt_busy_after", busy, 0);
        check_eq("tgt_hold", match_count, 2);
        check_eq("tgt_dones", dones, 1);

        // Stop together with the completing 4th bit
        cfg_target = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        feed(3'b101, 3);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("stop_match", match, 1);
        check_eq("stop_done", done, 1);
        check_eq("stop_count", match_count, 1);
        idle(2);
        check_eq("stop_idle", busy, 0);

        // Gapped valid bits, then reset mid-run
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("gap_pulses", pulses, 1);
        feed(2'b10, 2);
        dones = 0;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("midrst_count", match_count, 0);
        check_eq("midrst_dones", dones, 0);
        check_eq("midrst_busy", busy, 0);

        // Random traffic; cfg keeps changing to show it is latched only on start
        for (int c = 0; c < 1500; c++) begin
            cfg_pattern = 4'($urandom_range(0, 15));
            cfg_target  = 3'($urandom_range(0, 4));
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 39) == 0),
                 1'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_match_ctrl.md
SEQ_MATCH_CTRL -- requirements
Module: seq_match_ctrl

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..8.
REQ-002 Parameter CNT_W, default 8: width of the match target and the match counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-005 start  input  1  one-cycle request to begin a detection run.
REQ-006 stop  input  1  one-cycle request to abort a run.
REQ-007 cfg_pattern  input  PAT_W  target bit pattern; MSB is the first bit received.
REQ-008 cfg_target  input  CNT_W  number of matches that ends the run; 0 = unlimited.
REQ-009 in  input  1  serial data bit.
REQ-010 in_valid  input  1  qualifies in; bits without in_valid are ignored.
REQ-011 busy  output  1  high while the FSM is in RUN.
REQ-012 match  output  1  registered one-cycle pulse per detected pattern.
REQ-013 match_count  output  CNT_W  matches counted in the current or last run.
REQ-014 done  output  1  registered one-cycle pulse when a run ends by target or by stop.

Function
REQ-015 FSM has three states: IDLE, RUN and FIN; FIN lasts exactly one cycle and then returns to IDLE.
REQ-016 IDLE->RUN on start=1: latch cfg_pattern and cfg_target, clear the history register and its fill counter, and clear match_count.
REQ-017 start in RUN or FIN is ignored, and the latched configuration is not changed mid-run.
REQ-018 In RUN, each cycle with in_valid=1 shifts in into a PAT_W-bit history register (LSB = newest) and increments the fill counter, saturating at PAT_W.
REQ-019 A match occurs in a cycle where the fill counter, after the update, equals PAT_W and the history equals the latched pattern.
REQ-020 On a match, match pulses high in the following cycle and match_count increments in the same following cycle.
REQ-021 Without SEQ_OVERLAP_EN, a match clears the fill counter (non-overlapping detection).
REQ-022 match_count saturates at 2^CNT_W-1 when cfg_target=0.
REQ-023 RUN->FIN when match_count reaches a nonzero latched target; done and the final match pulse are asserted in the same cycle.
REQ-024 RUN->FIN on stop=1; a match detected in that same cycle is still counted and pulsed.
REQ-025 stop in IDLE or FIN has no effect.
REQ-026 If start and stop are both high in IDLE, start wins and stop is ignored.
REQ-027 match_count holds its value in IDLE until the next start.
REQ-028 busy=0 in IDLE and FIN; no bits are shifted outside RUN.

Reset
REQ-029 When reset=0 at a clock edge, the block goes to IDLE and sets busy=0, match=0, done=0 and match_count=0.
REQ-030 The history register, fill counter and latched configuration are also cleared on reset.
REQ-031 Reset applied mid-run aborts the run without a done pulse.
REQ-032 Reset takes priority over start and stop.

Configuration
REQ-033 Macro SEQ_OVERLAP_EN: when it is defined, a match does not clear the fill counter, so overlapping patterns are each detected.
REQ-034 When SEQ_OVERLAP_EN is undefined, detection is non-overlapping as specified in REQ-021.
REQ-035 All other behaviour is identical with and without SEQ_OVERLAP_EN.

Verification
REQ-036 The bench shall check: reset=0 for 2 cycles, then release -> busy=0, match=0, done=0, match_count=0.
REQ-037 The bench shall check: pattern 1010, target 0, valid stream 1,0,1,0,1,0 with SEQ_OVERLAP_EN undefined -> 1 match pulse, match_count=1.
REQ-038 The bench shall check: the same stream with SEQ_OVERLAP_EN defined -> match pulses after the 4th and 6th bits, match_count=2.
REQ-039 The bench shall check: pattern 1010, target 2, stream 1010 1010 -> done together with the 2nd match, busy=0 on the next cycle, further bits ignored.
REQ-040 The bench shall check: stop in the same cycle as the 4th bit of 1010 -> match=1, match_count=1, done=1, then IDLE.
REQ-041 The bench shall check: in_valid=0 gaps between the bits 1,0,1,0 -> still 1 match, and reset=0 mid-run -> count 0 with no done pulse.
